brew_arbiter: RTL
=================

BREW_ARBITER -- requirements
Module: brew_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 32'd660_000_000, the maximum number of BREW cycles before a fault (60 s at 11 MHz).
REQ-002 SHALL have parameter RINSE_CYC, default 32'd1_100_000, the number of RINSE cycles between brews (100 ms).
REQ-003 SHALL have port clk11m  in  1  the single clock, with all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  the reset, synchronous and active-high.
REQ-005 SHALL have port req  in  2  per-station paid request, one bit per station; a rising edge means the coin logic has accepted payment.
REQ-006 SHALL have port cup_present  in  2  per-station cup sensor, high when a cup is in place.
REQ-007 SHALL have port machine_empty  in  1  high when the shared brew unit is out of supplies.
REQ-008 SHALL have port coffee_ready  in  1  level signal from the shared brew unit, high when the brew is complete.
REQ-009 SHALL have port prepare_coffee  out  1  brew command to the shared unit.
REQ-010 SHALL have port sel  out  1  station index routed to the spout; valid while prepare_coffee is high.
REQ-011 SHALL have port lock_slit  out  2  per-station coin-slit lock.
REQ-012 SHALL have port done  out  2  per-station one-cycle pulse marking a completed brew.
REQ-013 SHALL have port fault  out  1  sticky brew-timeout fault indication.

Function
REQ-014 SHALL keep one pending flag per station.
- Set: cycle after a rising edge of req[i] (edge detect on a registered copy).
- Cleared: in the same cycle that done[i] pulses.
- Set request is ignored while the flag is already set or station i is being served; the clear wins on collision.
REQ-015 SHALL drive lock_slit[i] = pending[i] OR (station i being served).
REQ-016 SHALL implement the states IDLE, BREW, RINSE and FAULT with a registered state.
- All outputs except done are decoded from state and registers.
REQ-017 In IDLE, SHALL treat station i as eligible when pending[i] AND cup_present[i] AND NOT machine_empty.
- If any station is eligible: go to BREW next cycle, load the granted index into a registered sel, clear the timer.
REQ-018 SHALL arbitrate round-robin.
- With both stations eligible, grant the station other than the last one served.
- The last-served pointer resets to 1, so station 0 wins the first tie.
REQ-019 SHALL hold prepare_coffee high for exactly the cycles spent in BREW and low otherwise.
- Latency: req edge in cycle n, pending set in n+1, BREW and prepare_coffee in n+2 (idle and eligible).
REQ-020 In BREW, when coffee_ready is sampled high, SHALL:
- pulse done[sel] for one cycle;
- clear pending[sel];
- update the last-served pointer;
- go to RINSE.
REQ-021 In BREW, SHALL treat cup_present[sel] low as an abort.
- Go to RINSE; no done pulse; pending[sel] is retained so the paid brew is retried.
- This check has priority over coffee_ready in the same cycle.
REQ-022 In BREW, SHALL ignore machine_empty; the running brew completes or times out.
REQ-023 In BREW, when the timer reaches TIMEOUT_CYC-1 without completion or abort, SHALL go to FAULT.
REQ-024 In RINSE, SHALL count the timer from 0 to RINSE_CYC-1, then return to IDLE.
- Pending requests are granted no earlier than the IDLE cycle after RINSE ends.
REQ-025 In FAULT, SHALL:
- hold fault high and prepare_coffee low;
- retain pending flags and keep lock_slit asserted per REQ-015;
- leave FAULT only on rst.
REQ-026 SHALL share one 32-bit timer between BREW and RINSE, clearing it on every state change and never wrapping.
REQ-027 SHALL ignore coffee_ready outside BREW.

Reset
REQ-028 On rst high at a clock edge, SHALL apply:
- state = IDLE;
- pending = 0, timer = 0, sel = 0, last-served = 1;
- registered req copy = 0;
- all outputs low.
REQ-029 SHALL abandon any in-progress brew on reset mid-BREW, with no done pulse and pending cleared.

Structure
REQ-030 SHALL place the state enum, NSTATION=2 and the default TIMEOUT_CYC/RINSE_CYC constants in shared package coffee_pkg.
REQ-031 SHALL place the two-way round-robin grant logic in sub-module rr_arb2 (inputs: eligible[1:0], last; outputs: grant_valid, grant_idx).

Verification
REQ-032 (TIMEOUT_CYC=100, RINSE_CYC=8 for all scenarios) The bench SHALL cover these directed scenarios:
- Single brew: req[0] edge at cycle 10, cup_present=2'b11, coffee_ready high at 30 -> prepare_coffee high cycles 12..30, sel=0, done[0] at 31, IDLE at 39.
- Tie: both req edges in the same cycle -> station 0 served first; station 1 granted immediately after RINSE; lock_slit[1] high throughout.
- Abort: cup_present[1] drops mid-brew -> RINSE, no done; pending[1] kept; re-grant after the cup returns.
- Timeout: coffee_ready never arrives -> FAULT at BREW cycle 100, fault=1; further reqs are not granted until rst.
- Empty: machine_empty high with pending[0] -> stays in IDLE; grant occurs the cycle after machine_empty falls.
- Reset mid-BREW: rst pulse -> every output low the next cycle and pending=0.

Source files
------------

// File: rtl/coffee_pkg.sv
// Shared definitions for the two-station coffee dispenser arbiter:
// controller states, station count, default timing constants.
package coffee_pkg;

    localparam int NSTATION = 2;

    // 60 s brew limit and 100 ms rinse at the 11 MHz system clock
    localparam logic [31:0] TIMEOUT_CYC_DEF = 32'd660_000_000;
    localparam logic [31:0] RINSE_CYC_DEF   = 32'd1_100_000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREW  = 2'd1,
        RINSE = 2'd2,
        FAULT = 2'd3
    } brew_state_t;

    // One-hot station mask from a station index
    function automatic logic [NSTATION-1:0] station_onehot(input logic idx);
        logic [NSTATION-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/brew_arbiter_if.sv
// Station / brew-unit signal bundle seen by the arbiter.
// slave  : the arbiter side (consumes requests and sensors, drives commands)
// master : the environment side (coin logic, cup sensors, brew unit)
interface brew_arbiter_if;
    import coffee_pkg::*;

    logic [NSTATION-1:0] req;
    logic [NSTATION-1:0] cup_present;
    logic                machine_empty;
    logic                coffee_ready;
    logic                prepare_coffee;
    logic                sel;
    logic [NSTATION-1:0] lock_slit;
    logic [NSTATION-1:0] done;
    logic                fault;

    modport master (
        output req, cup_present, machine_empty, coffee_ready,
        input  prepare_coffee, sel, lock_slit, done, fault
    );

    modport slave (
        input  req, cup_present, machine_empty, coffee_ready,
        output prepare_coffee, sel, lock_slit, done, fault
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone eligible station always wins; on a
// tie the station other than the last one served wins.
module rr_arb2 (
    input  logic [1:0] eligible,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_idx
);

    // Pick the winner from the eligible mask and the last-served pointer
    always_comb begin
        grant_valid = |eligible;
        grant_idx   = 1'b0;
        case (eligible)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/brew_arbiter.sv
// Shares one brew unit between two paid stations. Paid requests are latched
// as pending flags, granted round-robin when the cup is present and supplies
// are available, brewed until the unit reports ready (or the cup is pulled,
// or the brew times out), then followed by a fixed rinse period.
module brew_arbiter
    import coffee_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter logic [31:0] RINSE_CYC   = RINSE_CYC_DEF
) (
    input  logic           clk11m,
    input  logic           rst,
    brew_arbiter_if.slave  bus
);

    brew_state_t         state_q, state_d;
    logic [31:0]         timer_q, timer_d;
    logic [NSTATION-1:0] req_p1;
    logic [NSTATION-1:0] pending_q, pending_d;
    logic [NSTATION-1:0] done_q, done_d;
    logic                sel_q, sel_d;
    logic                last_q, last_d;

    logic [NSTATION-1:0] req_rise;
    logic [NSTATION-1:0] serving;
    logic [NSTATION-1:0] eligible;
    logic [NSTATION-1:0] set_mask;
    logic                grant_valid;
    logic                grant_idx;

    rr_arb2 u_rr_arb2 (
        .eligible    (eligible),
        .last        (last_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Request edge detect, station-in-service mask and grant eligibility
    always_comb begin
        req_rise = bus.req & ~req_p1;
        serving  = '0;
        if (state_q == BREW) begin
            serving = station_onehot(sel_q);
        end
        eligible = pending_q & bus.cup_present & {NSTATION{~bus.machine_empty}};
        // A new payment is only latched for an idle, unserved station
        set_mask = req_rise & ~pending_q & ~serving;
    end

    // Next-state, completion pulse and pending-flag update
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        done_d    = '0;
        timer_d   = timer_q;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = BREW;
                    sel_d   = grant_idx;
                end
            end
            BREW: begin
                // Cup removal aborts the brew but keeps the paid request
                if (!bus.cup_present[sel_q]) begin
                    state_d = RINSE;
                end else if (bus.coffee_ready) begin
                    done_d  = station_onehot(sel_q);
                    last_d  = sel_q;
                    state_d = RINSE;
                end else if (timer_q == TIMEOUT_CYC - 32'd1) begin
                    state_d = FAULT;
                end
            end
            RINSE: begin
                if (timer_q == RINSE_CYC - 32'd1) begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
        endcase

        // Timer restarts on every state change and saturates instead of wrapping
        if (state_d != state_q) begin
            timer_d = '0;
        end else if ((state_q == BREW || state_q == RINSE) && timer_q != 32'hFFFF_FFFF) begin
            timer_d = timer_q + 32'd1;
        end

        // Completion clear wins over a simultaneous new request
        pending_d = (pending_q | set_mask) & ~done_d;
    end

    // State, timer, request history and bookkeeping registers
    always_ff @(posedge clk11m) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            req_p1    <= '0;
            pending_q <= '0;
            done_q    <= '0;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            req_p1    <= bus.req;
            pending_q <= pending_d;
            done_q    <= done_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
        end
    end

    assign bus.prepare_coffee = (state_q == BREW);
    assign bus.sel            = sel_q;
    assign bus.lock_slit      = pending_q | serving;
    assign bus.done           = done_q;
    assign bus.fault          = (state_q == FAULT);

endmodule
